// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS1   = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } btn_state_e;

  localparam int LONG_CYC_DEFAULT = 20;
  localparam int GAP_CYC_DEFAULT  = 10;

  // Width needed to hold the larger of the two thresholds without wrapping.
  function automatic int cnt_width(input int long_cyc, input int gap_cyc);
    int max_v;
    max_v = (long_cyc > gap_cyc) ? long_cyc : gap_cyc;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/btn_event_timer.sv
// Saturating up-counter with clear and increment enables; clear+increment loads 1.
module btn_event_timer
  import btn_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load, clear, saturating increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i && inc_i) begin
      cnt_d = WIDTH'(1);
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies button presses into short / long / double-click pulses.
// Double-click detection (GAP state, o_double) is built only with BTN_DOUBLE_CLICK_EN.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int LONG_CYC = LONG_CYC_DEFAULT,
  parameter int GAP_CYC  = GAP_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_busy
);

  localparam int CW = cnt_width(LONG_CYC, GAP_CYC);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
`endif

  if (LONG_CYC < 2) begin : g_bad_long
    $error("btn_event_decoder: LONG_CYC must be >= 2");
  end
  if (GAP_CYC < 2) begin : g_bad_gap
    $error("btn_event_decoder: GAP_CYC must be >= 2");
  end

  btn_state_e    state_q;
  btn_state_e    state_d;
  logic          short_q;
  logic          short_d;
  logic          long_q;
  logic          long_d;
  logic          busy_q;
  logic          cnt_clr_s;
  logic          cnt_inc_s;
  logic [CW-1:0] cnt_s;
`ifdef BTN_DOUBLE_CLICK_EN
  logic          double_q;
  logic          double_d;
`endif

  // One counter serves as press length N in PRESS1 and release gap G in GAP.
  btn_event_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr_s),
    .inc_i (cnt_inc_s),
    .cnt_o (cnt_s)
  );

  // Next-state, counter control and pulse decisions.
  always_comb begin
    state_d   = state_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
    double_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_clr_s = 1'b1;
        if (i_btn) begin
          state_d   = PRESS1;
          cnt_inc_s = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      PRESS1: begin
        if (i_btn) begin
          // The sample that brings N up to LONG_CYC fires the long pulse.
          if (cnt_s >= LONG_LAST) begin
            state_d   = WAIT_REL;
            long_d    = 1'b1;
            cnt_clr_s = 1'b1;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end else begin
`ifdef BTN_DOUBLE_CLICK_EN
          state_d   = GAP;
          cnt_clr_s = 1'b1;
          cnt_inc_s = 1'b1;
`else
          state_d   = IDLE;
          short_d   = 1'b1;
          cnt_clr_s = 1'b1;
`endif
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      GAP: begin
        if (!i_btn) begin
          if (cnt_s >= GAP_LAST) begin
            state_d   = IDLE;
            short_d   = 1'b1;
            cnt_clr_s = 1'b1;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end else begin
          state_d   = WAIT_REL;
          double_d  = 1'b1;
          cnt_clr_s = 1'b1;
        end
      end
`endif
      WAIT_REL: begin
        cnt_clr_s = 1'b1;
        if (!i_btn) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_REL;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
      double_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      long_q   <= long_d;
      busy_q   <= (state_d != IDLE);
`ifdef BTN_DOUBLE_CLICK_EN
      double_q <= double_d;
`endif
    end
  end

  assign o_short  = short_q;
  assign o_long   = long_q;
  assign o_busy   = busy_q;
`ifdef BTN_DOUBLE_CLICK_EN
  assign o_double = double_q;
`else
  assign o_double = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder: directed scenarios plus random press/release runs.
module tb_btn_event_decoder;
  import btn_pkg::*;

  localparam int LONG = LONG_CYC_DEFAULT;
  localparam int GAPC = GAP_CYC_DEFAULT;

  logic clk;
  logic rst;
  logic i_btn;
  logic o_short;
  logic o_long;
  logic o_double;
  logic o_busy;

  int n_checks;
  int n_fail;
  int tally_s;
  int tally_l;
  int tally_d;

  // Reference model: samples of the current episode and a "wait for release" flag.
  bit m_q[$];
  bit m_hold;
  bit exp_short;
  bit exp_long;
  bit exp_double;
  bit exp_busy;

  btn_event_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (i_btn),
    .o_short  (o_short),
    .o_long   (o_long),
    .o_double (o_double),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pattern match on the episode: 1^LONG -> long; 1^a 0^GAP -> short; 1^a 0^g 1 -> double.
  task automatic model_step(input bit b);
    int lead;
    exp_short  = 1'b0;
    exp_long   = 1'b0;
    exp_double = 1'b0;
    if (m_hold) begin
      if (!b) m_hold = 1'b0;
    end else if (m_q.size() == 0) begin
      if (b) m_q.push_back(1'b1);
    end else begin
      m_q.push_back(b);
      lead = 0;
      while (lead < m_q.size() && m_q[lead]) lead++;
      if (lead == m_q.size()) begin
        if (lead >= LONG) begin
          exp_long = 1'b1;
          m_hold   = 1'b1;
          m_q.delete();
        end
      end else begin
`ifdef BTN_DOUBLE_CLICK_EN
        if (b) begin
          exp_double = 1'b1;
          m_hold     = 1'b1;
          m_q.delete();
        end else if (m_q.size() - lead >= GAPC) begin
          exp_short = 1'b1;
          m_q.delete();
        end
`else
        exp_short = 1'b1;
        m_q.delete();
`endif
      end
    end
    exp_busy = m_hold || (m_q.size() != 0);
  endtask

  task automatic compare_all(input string ctx);
    check_bit({ctx, "_short"},  o_short,  exp_short);
    check_bit({ctx, "_long"},   o_long,   exp_long);
    check_bit({ctx, "_double"}, o_double, exp_double);
    check_bit({ctx, "_busy"},   o_busy,   exp_busy);
    check_bit({ctx, "_onehot"}, $onehot0({o_short, o_long, o_double}), 1'b1);
    if (o_short)  tally_s++;
    if (o_long)   tally_l++;
    if (o_double) tally_d++;
  endtask

  task automatic step(input bit b, input string ctx);
    @(negedge clk);
    rst   = 1'b0;
    i_btn = b;
    @(posedge clk);
    #1;
    model_step(b);
    compare_all(ctx);
  endtask

  task automatic run(input bit b, input int len, input string ctx);
    for (int i = 0; i < len; i++) step(b, ctx);
  endtask

  task automatic do_reset(input bit b);
    @(negedge clk);
    rst   = 1'b1;
    i_btn = b;
    @(posedge clk);
    #1;
    m_q.delete();
    m_hold     = 1'b0;
    exp_short  = 1'b0;
    exp_long   = 1'b0;
    exp_double = 1'b0;
    exp_busy   = 1'b0;
    compare_all("reset");
  endtask

  task automatic clear_tally();
    tally_s = 0;
    tally_l = 0;
    tally_d = 0;
  endtask

  task automatic check_tally(input string ctx, input int es, input int el, input int ed);
    check_int({ctx, "_n_short"},  tally_s, es);
    check_int({ctx, "_n_long"},   tally_l, el);
    check_int({ctx, "_n_double"}, tally_d, ed);
  endtask

  initial begin
    bit lvl;
    int len;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    i_btn    = 1'b0;
    clear_tally();

    do_reset(1'b0);
    do_reset(1'b1);

    // Short press: 5 high, 10+ low.
    clear_tally();
    run(1'b1, 5, "short");
    run(1'b0, 12, "short");
    check_tally("short", 1, 0, 0);

    // Long hold of 30 samples.
    clear_tally();
    run(1'b1, 30, "long");
    run(1'b0, 3, "long");
    check_tally("long", 0, 1, 0);

    // Two presses separated by a 4-sample gap.
    clear_tally();
    run(1'b1, 5, "dbl");
    run(1'b0, 4, "dbl");
    run(1'b1, 5, "dbl");
    run(1'b0, 12, "dbl");
`ifdef BTN_DOUBLE_CLICK_EN
    check_tally("dbl", 0, 0, 1);
`else
    check_tally("dbl", 2, 0, 0);
`endif

    // Second press held past LONG still yields only the double.
    clear_tally();
    run(1'b1, 3, "dbl_hold");
    run(1'b0, 2, "dbl_hold");
    run(1'b1, 30, "dbl_hold");
    run(1'b0, 12, "dbl_hold");
`ifdef BTN_DOUBLE_CLICK_EN
    check_tally("dbl_hold", 0, 0, 1);
`else
    check_tally("dbl_hold", 1, 1, 0);
`endif

    // Reset mid-hold at N=15 with the button kept high.
    clear_tally();
    run(1'b1, 15, "rst_mid");
    do_reset(1'b1);
    run(1'b1, 19, "rst_mid");
    check_tally("rst_mid_pre", 0, 0, 0);
    run(1'b1, 1, "rst_mid");
    check_int("rst_mid_long_at_20", tally_l, 1);
    run(1'b1, 5, "rst_mid");
    run(1'b0, 3, "rst_mid");
    check_tally("rst_mid", 0, 1, 0);

    // Gap of exactly GAP_CYC low samples: short, then a fresh press.
    clear_tally();
    run(1'b1, 5, "gap_edge");
    run(1'b0, GAPC, "gap_edge");
    check_tally("gap_edge_first", 1, 0, 0);
    run(1'b1, 5, "gap_edge");
    run(1'b0, 12, "gap_edge");
    check_tally("gap_edge", 2, 0, 0);

    // Random alternating runs with occasional resets.
    lvl = 1'b1;
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end
      len = $urandom_range(1, 26);
      run(lvl, len, "rand");
      lvl = ~lvl;
    end
    run(1'b0, 15, "rand_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
